// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//
// Branch resolution stage for the pipelined MIPS core. It sits in the ID
// stage after the forwarding muxes. The unit does the following:
//   - Accepts one branch per cycle.
//   - Holds a branch in WAIT until its forwarded operands are final.
//   - Registers the taken/not-taken decision, the link flag and a
//     prediction/mispredict pair for the fetch stage.
//
// Optional feature macro: BRANCH_BHT_EN
//   defined   : a table of 2-bit saturating counters supplies the prediction.
//   undefined : static not-taken prediction, so predicted is always 0 and
//               mispredict follows branch.
//
// Parameters:
//   WIDTH     operand width
//   PC_WIDTH  PC width
//   BHT_DEPTH number of counters (power of two, >= 2)
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   in_valid    branch presented this cycle
//   in_ready    unit can accept a branch this cycle
//   op          branch opcode. The encodings are:
//                 0 beq, 1 bgez, 2 bgtz, 3 blez, 4 bltz, 5 bne,
//                 6 bgezal, 7 bltzal, 8 b, 9-15 never taken
//   a1, a2      forwarded operands
//   pc          PC of the branch
//   operand_ok  a1/a2 are final this cycle
//   flush       kill any pending branch
//   out_valid   one-cycle pulse marking valid result registers
//   branch      resolved taken
//   link        taken link-type branch (ops 6 and 7)
//   predicted   prediction captured at accept
//   mispredict  predicted differs from branch

module branch_resolve_unit #(
    parameter int WIDTH     = 32,
    parameter int PC_WIDTH  = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          op,
    input  logic [WIDTH-1:0]    a1,
    input  logic [WIDTH-1:0]    a2,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                operand_ok,
    input  logic                flush,
    output logic                out_valid,
    output logic                branch,
    output logic                link,
    output logic                predicted,
    output logic                mispredict
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t              state;
    logic [3:0]          op_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic                pred_q;

    logic                accept;
    logic                resolve;
    logic [3:0]          res_op;
    logic [PC_WIDTH-1:0] res_pc;
    logic                pred_rd;
    logic                res_pred;
    logic                taken;
    logic                is_link;

    // Decide whether a branch with opcode o is taken for operands x and y.
    // The single-operand compares treat x as signed, so the MSB is the sign bit.
    function automatic logic eval_taken(input logic [3:0] o,
                                        input logic [WIDTH-1:0] x,
                                        input logic [WIDTH-1:0] y);
        logic neg;
        logic zero;
        logic t;
        neg  = x[WIDTH-1];
        zero = (x == '0);
        case (o)
            4'd0:        t = (x == y);
            4'd1, 4'd6:  t = ~neg;
            4'd2:        t = ~neg & ~zero;
            4'd3:        t = neg | zero;
            4'd4, 4'd7:  t = neg;
            4'd5:        t = (x != y);
            4'd8:        t = 1'b1;
            default:     t = 1'b0;
        endcase
        return t;
    endfunction

    assign in_ready = (state == IDLE) && !flush;
    assign accept   = in_valid && in_ready;

    // A branch resolves in two cases. It can resolve directly from IDLE
    // when accepted with final operands. It can also resolve from WAIT once
    // operands are final. A flush in WAIT takes priority over operand_ok.
    assign resolve = (accept && operand_ok) ||
                     ((state == WAIT) && operand_ok && !flush);

    // From IDLE the live op/pc are used. In WAIT the latched copies are used,
    // while a1/a2 always come live from the forwarding network.
    assign res_op   = (state == IDLE) ? op : op_q;
    assign res_pc   = (state == IDLE) ? pc : pc_q;
    assign res_pred = (state == IDLE) ? pred_rd : pred_q;

    assign taken   = eval_taken(res_op, a1, a2);
    assign is_link = (res_op == 4'd6) || (res_op == 4'd7);

`ifdef BRANCH_BHT_EN
    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    assign rd_idx  = pc[IDX_W+1:2];
    assign wr_idx  = res_pc[IDX_W+1:2];
    assign pred_rd = bht[rd_idx][1];

    // Saturating 2-bit counters, updated only at a resolve edge. A
    // combinational read therefore sees the previous edge's write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (resolve) begin
            if (taken && bht[wr_idx] != 2'b11) begin
                bht[wr_idx] <= bht[wr_idx] + 2'b01;
            end else if (!taken && bht[wr_idx] != 2'b00) begin
                bht[wr_idx] <= bht[wr_idx] - 2'b01;
            end
        end
    end
`else
    // Static not-taken prediction.
    assign pred_rd = 1'b0;
`endif

    // Some PC bits are never looked at (alignment bits, bits above the
    // table index, or the whole PC when there is no table).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc, res_pc, IDX_W[0]};

    // Control FSM and registered results. In IDLE, op/pc/prediction are
    // captured on every accept, so a branch entering WAIT keeps them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            op_q       <= '0;
            pc_q       <= '0;
            pred_q     <= 1'b0;
            out_valid  <= 1'b0;
            branch     <= 1'b0;
            link       <= 1'b0;
            predicted  <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            out_valid <= resolve;
            if (resolve) begin
                branch     <= taken;
                link       <= taken && is_link;
                predicted  <= res_pred;
                mispredict <= taken ^ res_pred;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= op;
                        pc_q   <= pc;
                        pred_q <= pred_rd;
                        if (!operand_ok) begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (flush || operand_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit
//
// Scoreboard bench for branch_resolve_unit. Each issued branch that will
// resolve pushes its hand-computed result and the cycle it must appear in.
// A monitor pops and compares whenever out_valid is high. The bench applies
// direct checks for reset values, in_ready, flush and reset during WAIT.
// Expected predictions depend on whether BRANCH_BHT_EN is defined.

module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] pc;
    logic        operand_ok;
    logic        flush;
    logic        out_valid;
    logic        branch;
    logic        link;
    logic        predicted;
    logic        mispredict;

    typedef struct {
        logic [3:0] res;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cycle_cnt = 0;

    branch_resolve_unit #(
        .WIDTH(32),
        .PC_WIDTH(32),
        .BHT_DEPTH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op(op),
        .a1(a1),
        .a2(a2),
        .pc(pc),
        .operand_ok(operand_ok),
        .flush(flush),
        .out_valid(out_valid),
        .branch(branch),
        .link(link),
        .predicted(predicted),
        .mispredict(mispredict)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Compare one value and record the outcome.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one branch. The accept happens at the next rising edge. If
    // operands are final, the result must show up one cycle after that edge.
    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] p, input logic ok,
                                 input logic eb, input logic el, input logic ep);
        exp_t e;
        @(negedge clk);
        in_valid   = 1'b1;
        op         = o;
        a1         = x;
        a2         = y;
        pc         = p;
        operand_ok = ok;
        flush      = 1'b0;
        if (ok) begin
            e.res = {eb, el, ep, eb ^ ep};
            e.cyc = cycle_cnt + 1;
            sb.push_back(e);
        end
    endtask

    task automatic idleCycle(input logic ok);
        @(negedge clk);
        in_valid   = 1'b0;
        operand_ok = ok;
        flush      = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        op         = 4'd0;
        a1         = '0;
        a2         = '0;
        pc         = '0;
        operand_ok = 1'b0;
        flush      = 1'b0;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (reset && out_valid) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_out_valid", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("result_bits", {28'd0, branch, link, predicted, mispredict}, {28'd0, e.res});
                        checkOutput("latency_cycle", cycle_cnt, e.cyc);
                    end
                end
            end
        join_none

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_outputs", {27'd0, out_valid, branch, link, predicted, mispredict}, 32'd0);
        reset = 1'b1;

        // Back-to-back single-cycle resolves, each on its own counter index
        applyStimulus(4'd0, 32'h1234,     32'h1234, 32'h04, 1'b1, 1'b1, 1'b0, 1'b0); // beq
        applyStimulus(4'd5, 32'h1234,     32'h1234, 32'h08, 1'b1, 1'b0, 1'b0, 1'b0); // bne
        applyStimulus(4'd7, 32'h80000000, 32'h0,    32'h0C, 1'b1, 1'b1, 1'b1, 1'b0); // bltzal
        applyStimulus(4'd2, 32'h0,        32'h0,    32'h10, 1'b1, 1'b0, 1'b0, 1'b0); // bgtz 0
        applyStimulus(4'd3, 32'h0,        32'h0,    32'h14, 1'b1, 1'b1, 1'b0, 1'b0); // blez 0
        applyStimulus(4'd12, 32'h5,       32'h5,    32'h18, 1'b1, 1'b0, 1'b0, 1'b0); // unknown
        applyStimulus(4'd6, 32'h0,        32'h0,    32'h1C, 1'b1, 1'b1, 1'b1, 1'b0); // bgezal 0
        applyStimulus(4'd1, 32'hFFFFFFFF, 32'h0,    32'h20, 1'b1, 1'b0, 1'b0, 1'b0); // bgez -1
        applyStimulus(4'd8, 32'h0,        32'h1,    32'h30, 1'b1, 1'b1, 1'b0, 1'b0); // b
        applyStimulus(4'd4, 32'h7FFFFFFF, 32'h0,    32'h34, 1'b1, 1'b0, 1'b0, 1'b0); // bltz +
        idleCycle(1'b0);

        // WAIT: operands change while pending, resolve with final ones
        applyStimulus(4'd0, 32'h5, 32'h7, 32'h24, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idleCycle(1'b0);
            a1 = 32'h100 + i;
            a2 = 32'h55;
            #1 checkOutput("wait_in_ready", {31'd0, in_ready}, 32'd0);
        end
        begin
            exp_t e;
            @(negedge clk);
            a1 = 32'h55;
            a2 = 32'h55;
            operand_ok = 1'b1;
            e.res = 4'b1001;
            e.cyc = cycle_cnt + 1;
            sb.push_back(e);
        end
        idleCycle(1'b0);
        idleCycle(1'b0);

        // Flush in WAIT wins over operand_ok, then no out_valid
        applyStimulus(4'd5, 32'h1, 32'h2, 32'h2C, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid   = 1'b0;
        operand_ok = 1'b1;
        flush      = 1'b1;
        #1 checkOutput("flush_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        flush      = 1'b0;
        operand_ok = 1'b0;
        #1 checkOutput("flush_in_ready_next", {31'd0, in_ready}, 32'd1);
        checkOutput("flush_no_out_valid", {31'd0, out_valid}, 32'd0);

        // Flush in IDLE blocks an accept
        @(negedge clk);
        in_valid   = 1'b1;
        op         = 4'd8;
        operand_ok = 1'b1;
        flush      = 1'b1;
        #1 checkOutput("idle_flush_in_ready", {31'd0, in_ready}, 32'd0);
        idleCycle(1'b0);
        #1 checkOutput("idle_flush_no_out_valid", {31'd0, out_valid}, 32'd0);

        // Reset during WAIT: back to reset values, no stale resolve after
        applyStimulus(4'd0, 32'h9, 32'h9, 32'h38, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1 checkOutput("midwait_rst_outputs", {27'd0, out_valid, branch, link, predicted, mispredict}, 32'd0);
        checkOutput("midwait_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        idleCycle(1'b1);
        idleCycle(1'b1);
        idleCycle(1'b0);

        // Same pc, taken back-to-back, then saturation and a not-taken
`ifdef BRANCH_BHT_EN
        applyStimulus(4'd0, 32'h1, 32'h1, 32'h28, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'd0, 32'h1, 32'h1, 32'h28, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'd0, 32'h1, 32'h1, 32'h28, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'd0, 32'h1, 32'h1, 32'h28, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'd0, 32'h1, 32'h1, 32'h28, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'd0, 32'h1, 32'h2, 32'h28, 1'b1, 1'b0, 1'b0, 1'b1);
`else
        applyStimulus(4'd0, 32'h1, 32'h1, 32'h28, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'd0, 32'h1, 32'h1, 32'h28, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'd0, 32'h1, 32'h1, 32'h28, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'd0, 32'h1, 32'h1, 32'h28, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'd0, 32'h1, 32'h1, 32'h28, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'd0, 32'h1, 32'h2, 32'h28, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
        idleCycle(1'b0);
        repeat (3) @(negedge clk);
        #1 checkOutput("scoreboard_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch-resolution stage for the pipelined MIPS core, placed in the ID stage after the forwarding muxes. It generalises the branch comparator to configurable data/PC widths, adds link-type branches and an unconditional branch, holds a branch until its forwarded operands are valid, and registers the taken/not-taken decision. An optional table of 2-bit saturating counters supplies a prediction and a mispredict flag to the fetch stage.

## Interface
- WIDTH, 32, operand width in bits
- PC_WIDTH, 32, PC width in bits
- BHT_DEPTH, 16, number of counters; must be a power of two and at least 2
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  branch presented this cycle
- in_ready  out  1  unit can accept a branch this cycle
- op  in  4  0 beq, 1 bgez, 2 bgtz, 3 blez, 4 bltz, 5 bne, 6 bgezal, 7 bltzal, 8 b (always); 9–15 never taken
- a1, a2  in  WIDTH  forwarded operands; signed for ops 1–4, 6 and 7
- pc  in  PC_WIDTH  PC of the branch
- operand_ok  in  1  a1/a2 are final this cycle (no pending hazard)
- flush  in  1  kill any pending branch
- out_valid  out  1  one-cycle pulse: result registers valid
- branch  out  1  resolved taken
- link  out  1  taken and op is 6 or 7
- predicted  out  1  prediction captured at accept
- mispredict  out  1  predicted differs from branch

## Operation
- Two states, IDLE and WAIT.
- in_ready is 1 in IDLE with flush low, and 0 otherwise.
- Accept occurs when in_valid and in_ready are both high. On accept, latch op and pc, and capture predicted from the counter.
- Accept with operand_ok high: resolve at this edge using the current a1/a2. Stay in IDLE.
- Accept with operand_ok low: go to WAIT. Each WAIT cycle re-samples the live a1/a2. When operand_ok goes high, resolve with the latched op/pc and return to IDLE.
- flush: in WAIT, go to IDLE with no out_valid and no counter update. In IDLE, block accept for that cycle. flush wins over operand_ok in the same cycle.
- Unknown op codes (9–15) resolve as not taken with out_valid asserted; they are not treated as errors.
- Resolve edge:
  - Register branch, link, predicted and mispredict.
  - Set out_valid high for exactly one cycle.
  - Update the counter.
- Counter index is pc[log2(BHT_DEPTH)+1:2].
- Counter update saturates: +1 on taken, capped at 3; -1 on not taken, floored at 0.
- predicted is bit 1 of the counter read at accept.

## Timing
- Reset values: every output 0 except in_ready = 1; state = IDLE; all counters 2'b01.
- Reset asserted during WAIT: immediate return to IDLE; no out_valid is emitted.
- Latency: accept at edge N with operand_ok high gives out_valid high in cycle N+1.
- Each WAIT cycle adds one cycle of latency.
- Throughput: one branch per cycle, back-to-back.
- There is no output backpressure; the consumer samples whenever out_valid is high.
- Counter write at edge N is visible to an accept at edge N+1 at the same index (write-before-read across edges).
- Counter update at saturation holds the value: 3 stays 3 on taken, 0 stays 0 on not taken.

## Configuration
- BRANCH_BHT_EN defined: counter table instantiated; predicted and mispredict behave as above.
- BRANCH_BHT_EN undefined: no table; predicted is always 0 (static not-taken); mispredict equals branch.

## Test plan
- beq with a1 = a2 = 0x1234, operand_ok = 1: out_valid and branch = 1 one cycle later. Repeat as bne: branch = 0.
- bltzal with a1 = 0x80000000: branch = 1 and link = 1. bgtz with a1 = 0: branch = 0. blez with a1 = 0: branch = 1. op = 12: branch = 0 with out_valid = 1.
- Accept beq with operand_ok = 0 for 3 cycles while a1 changes, then operand_ok = 1 with a1 = a2: in_ready = 0 for those cycles, then out_valid with branch = 1 resolved from the final operands.
- In WAIT, assert flush: out_valid stays 0 and in_ready = 1 the next cycle. Assert reset mid-WAIT: outputs return to their reset values.
- BRANCH_BHT_EN defined, same pc, taken branches back-to-back: predicted sequence is 0, 1, 1, 1 and mispredict sequence is 1, 0, 0, 0. The counter saturates at 3; one not-taken then gives predicted = 1 and mispredict = 1.
- BRANCH_BHT_EN undefined, taken beq: predicted = 0 and mispredict = 1.
